// File: rtl/uart_pkg.sv
// Shared types and helpers for the uart receive blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-stage synchroniser for an asynchronous line that idles high.
module uart_rx_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= '1;
        else        ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with parity/framing checks and valid/ready output.
// states: IDLE wait start | START verify start | DATA shift bits | PARITY check | STOP deliver
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 7,
    parameter int OVERSAMPLE  = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy,
    output logic [2:0]           state_out
);

    localparam int CW = cnt_width(OVERSAMPLE);
    localparam int BW = cnt_width(DATA_BITS + 1);
    localparam logic [CW-1:0] MID      = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] LAST     = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          ODD      = (PARITY_ODD != 0);

    logic rx_s;

    uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    state_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [BW-1:0]        bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 par_err_q, par_err_nxt;
    logic                 load, frame_nxt, parity_nxt, ovr_nxt;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_nxt     = bit_cnt;
        shreg_nxt   = shreg;
        par_err_nxt = par_err_q;
        load        = 1'b0;
        frame_nxt   = 1'b0;
        parity_nxt  = 1'b0;
        ovr_nxt     = 1'b0;
        if (ena) begin
            cnt_nxt = cnt + CW'(1);
            case (state)
                IDLE: begin
                    cnt_nxt = '0;
                    if (!rx_s) begin
                        state_nxt   = START;
                        par_err_nxt = 1'b0;
                    end
                end
                START: begin
                    if (cnt == MID && rx_s) begin
                        state_nxt = IDLE;
                    end else if (cnt == LAST) begin
                        state_nxt = DATA;
                        bit_nxt   = '0;
                    end
                end
                DATA: begin
                    if (cnt == MID) begin
                        shreg_nxt                = shreg >> 1;
                        shreg_nxt[DATA_BITS-1]   = rx_s;
                    end
                    if (cnt == LAST) begin
                        if (bit_cnt == BIT_LAST)
                            state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                        else
                            bit_nxt = bit_cnt + BW'(1);
                    end
                end
                PARITY: begin
                    if (cnt == MID)  par_err_nxt = ^shreg ^ rx_s ^ ODD;
                    if (cnt == LAST) state_nxt = STOP;
                end
                STOP: begin
                    // Leave at mid-stop so a back-to-back start edge is not missed.
                    if (cnt == MID) begin
                        state_nxt = IDLE;
                        if (!rx_s)                      frame_nxt  = 1'b1;
                        else if (par_err_q)             parity_nxt = 1'b1;
                        else if (!valid_out || ready_in) load      = 1'b1;
                        else                            ovr_nxt    = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_cnt   <= bit_nxt;
            shreg     <= shreg_nxt;
            par_err_q <= par_err_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            valid_out  <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= frame_nxt;
            parity_err <= parity_nxt;
            overrun    <= ovr_nxt;
            if (load) begin
                data_out  <= shreg;
                valid_out <= 1'b1;
            end else if (valid_out && ready_in) begin
                valid_out <= 1'b0;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign state_out = state;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench: a default 7-bit receiver and an 8-bit even-parity receiver.
module tb_uart_rx_param;

    localparam int OS = 8;
    localparam int K_WORD = 1, K_FRM = 2, K_PAR = 3, K_OVR = 4, K_NONE = 0;

    typedef struct {
        int          dut;
        int          kind;
        logic [15:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b0;
    logic ready_in = 1'b1;
    logic rx0 = 1'b1, rx1 = 1'b1;
    logic [6:0] data0;
    logic [7:0] data1;
    logic valid0, valid1, fe0, fe1, pe0, pe1, ov0, ov1, busy0, busy1;
    logic [2:0] state0, state1;

    int   n_chk = 0, n_fail = 0;
    int   ena_div = 1, div_cnt = 0;
    ev_t  exp_q[$];

    logic [1:0]  vld, fe, pe, ov, acc_prev;
    logic [15:0] dout [2];
    assign vld  = {valid1, valid0};
    assign fe   = {fe1, fe0};
    assign pe   = {pe1, pe0};
    assign ov   = {ov1, ov0};
    assign dout[0] = {9'd0, data0};
    assign dout[1] = {8'd0, data1};

    uart_rx_param dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx0),
        .data_out(data0), .valid_out(valid0), .ready_in(ready_in),
        .frame_err(fe0), .parity_err(pe0), .overrun(ov0),
        .busy(busy0), .state_out(state0)
    );

    uart_rx_param #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rx(rx1),
        .data_out(data1), .valid_out(valid1), .ready_in(ready_in),
        .frame_err(fe1), .parity_err(pe1), .overrun(ov1),
        .busy(busy1), .state_out(state1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (div_cnt >= ena_div - 1) div_cnt = 0;
        else                        div_cnt = div_cnt + 1;
        ena = (div_cnt == 0);
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic handle_event(input int d, input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk_eq("unexpected_event", kind, K_NONE);
        end else begin
            e = exp_q.pop_front();
            chk_eq("event_dut", d, e.dut);
            chk_eq("event_kind", kind, e.kind);
            chk_eq("event_data", dout[d], e.data);
            if (kind == K_OVR) chk_eq("ovr_valid_held", vld[d], 1);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            acc_prev = 2'b00;
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (acc_prev[d]) chk_eq("valid_one_clk", vld[d], 0);
                if (vld[d] && ready_in) handle_event(d, K_WORD);
                if (fe[d]) handle_event(d, K_FRM);
                if (pe[d]) handle_event(d, K_PAR);
                if (ov[d]) handle_event(d, K_OVR);
                acc_prev[d] = vld[d] && ready_in;
            end
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (!ena);
            #1;
        end
    endtask

    task automatic set_rx(input int d, input logic v);
        if (d == 0) rx0 = v;
        else        rx1 = v;
    endtask

    task automatic push(input int d, input int kind, input logic [15:0] data);
        ev_t e;
        e.dut = d; e.kind = kind; e.data = data;
        exp_q.push_back(e);
    endtask

    // par < 0 means no parity bit is sent.
    task automatic send_frame(input int d, input logic [15:0] data, input int nbits,
                              input int par, input logic stop_v);
        set_rx(d, 1'b0);
        wait_ticks(OS);
        for (int i = 0; i < nbits; i++) begin
            set_rx(d, data[i]);
            wait_ticks(OS);
        end
        if (par >= 0) begin
            set_rx(d, par[0]);
            wait_ticks(OS);
        end
        set_rx(d, stop_v);
        wait_ticks(OS);
        set_rx(d, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_state", state0, 0);
        chk_eq("rst_busy", busy0, 0);
        chk_eq("rst_valid", valid0, 0);
        chk_eq("rst_data", data0, 0);
        chk_eq("rst_flags", {fe0, pe0, ov0, fe1, pe1, ov1}, 0);
        chk_eq("rst_state1", state1, 0);
        rst_n = 1'b1;
        wait_ticks(4);

        // basic frame, ena every clk
        push(0, K_WORD, 16'h55);
        fork
            send_frame(0, 16'h55, 7, -1, 1'b1);
            begin wait_ticks(4); chk_eq("start_state", state0, 1); end
        join
        wait_ticks(16);

        // ena every 4th clk
        ena_div = 4;
        wait_ticks(2);
        push(0, K_WORD, 16'h3A);
        fork
            send_frame(0, 16'h3A, 7, -1, 1'b1);
            begin wait_ticks(4); chk_eq("start_state_div4", state0, 1); end
        join
        wait_ticks(16);
        ena_div = 1;
        wait_ticks(4);

        // false start: rx low for 2 ticks only
        rx0 = 1'b0;
        wait_ticks(2);
        rx0 = 1'b1;
        wait_ticks(2);
        chk_eq("false_start_busy", busy0, 1);
        wait_ticks(10);
        chk_eq("false_start_idle_busy", busy0, 0);
        chk_eq("false_start_idle_state", state0, 0);

        // low stop bit
        push(0, K_FRM, 16'h3A);
        send_frame(0, 16'h12, 7, -1, 1'b0);
        wait_ticks(20);
        chk_eq("frame_err_no_valid", valid0, 0);

        // parity receiver: wrong then right parity
        push(1, K_PAR, 16'h0);
        send_frame(1, 16'hA5, 8, 1, 1'b1);
        wait_ticks(16);
        push(1, K_WORD, 16'hA5);
        send_frame(1, 16'hA5, 8, 0, 1'b1);
        wait_ticks(16);

        // overrun with consumer stalled
        ready_in = 1'b0;
        push(0, K_OVR, 16'h11);
        push(0, K_WORD, 16'h11);
        send_frame(0, 16'h11, 7, -1, 1'b1);
        send_frame(0, 16'h22, 7, -1, 1'b1);
        wait_ticks(4);
        chk_eq("held_valid", valid0, 1);
        chk_eq("held_data", data0, 7'h11);
        ready_in = 1'b1;
        wait_ticks(4);
        chk_eq("after_accept_valid", valid0, 0);

        // reset during data bit 3
        rx0 = 1'b0;
        wait_ticks(OS);
        rx0 = 1'b1;
        wait_ticks(3 * OS + 3);
        chk_eq("pre_reset_state", state0, 2);
        rst_n = 1'b0;
        #1;
        chk_eq("mid_reset_state", state0, 0);
        chk_eq("mid_reset_busy", busy0, 0);
        chk_eq("mid_reset_outs", {valid0, fe0, pe0, ov0}, 0);
        chk_eq("mid_reset_data", data0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ticks(16);
        push(0, K_WORD, 16'h7F);
        send_frame(0, 16'h7F, 7, -1, 1'b1);
        wait_ticks(24);

        chk_eq("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
